// File: rtl/adc_spi_responder_pkg.sv
// Shared SPI link constants and responder FSM encoding, also used by the adc block.
package adc_spi_responder_pkg;

  localparam int   ADC_SAMPLE_WIDTH = 24;

  // SPI mode 0: SCLK idles low, master samples on the rising edge.
  localparam logic SPI_CPOL    = 1'b0;
  localparam logic SPI_CPHA    = 1'b0;
  localparam logic SPI_CS_IDLE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } spi_state_t;

endpackage

// File: rtl/adc_spi_responder_if.sv
// Sample stream plus SPI pins between the adc master side and the responder.
interface adc_spi_responder_if #(
  parameter int TDATA_WIDTH = 32
);
  logic                   s_axis_tvalid;
  logic [TDATA_WIDTH-1:0] s_axis_tdata;
  logic                   s_axis_tready;
  logic                   s_spi_clk;
  logic                   s_spi_cs;
  logic                   s_spi_miso;

  modport master (
    output s_axis_tvalid, s_axis_tdata, s_spi_clk, s_spi_cs,
    input  s_axis_tready, s_spi_miso
  );

  modport slave (
    input  s_axis_tvalid, s_axis_tdata, s_spi_clk, s_spi_cs,
    output s_axis_tready, s_spi_miso
  );
endinterface

// File: rtl/adc_spi_responder_spi_sync_edge.sv
// Multi-flop synchronizer for an async pin with rise/fall strobes on the synchronized level.
// Strobes are valid STAGES clk after the raw transition; reset presets the chain to the pin's idle level.
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              dly;

  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= {STAGES{RESET_VAL}};
      dly   <= RESET_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      dly   <= chain[STAGES-1];
    end
  end

  assign rise = chain[STAGES-1] & ~dly;
  assign fall = ~chain[STAGES-1] & dly;

endmodule

// File: rtl/adc_spi_responder.sv
// SPI responder emulating the ADC: shifts held samples MSB-first on MISO, SYNC_STAGES+1 clk after a pin edge.
// s_axis_tready drops while a sample is held and reopens in the cycle that sample is loaded into a frame.
module adc_spi_responder
  import adc_spi_responder_pkg::*;
#(
  parameter int                    SAMPLE_WIDTH         = ADC_SAMPLE_WIDTH,
  parameter int                    C_S_AXIS_TDATA_WIDTH = 32,
  parameter int                    SYNC_STAGES          = 2,
  parameter logic [SAMPLE_WIDTH-1:0] IDLE_PATTERN       = '0,
  parameter int                    CNT_WIDTH            = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  adc_spi_responder_if.slave   bus,
  output logic                 frame_done,
  output logic                 underrun,
  output logic [CNT_WIDTH-1:0] underrun_cnt,
  output logic [CNT_WIDTH-1:0] frame_cnt
);

  localparam int                BCW      = (SAMPLE_WIDTH > 1) ? $clog2(SAMPLE_WIDTH) : 1;
  localparam logic [BCW-1:0]    LAST_BIT = BCW'(SAMPLE_WIDTH - 1);

  if (C_S_AXIS_TDATA_WIDTH < SAMPLE_WIDTH || SYNC_STAGES < 2) begin : g_param_check
    $fatal(1, "adc_spi_responder: tdata narrower than sample or SYNC_STAGES < 2");
  end

  spi_state_t              state, state_nxt;
  logic [SAMPLE_WIDTH-1:0] shreg, shreg_nxt, hold_data;
  logic [BCW-1:0]          bitcnt, bitcnt_nxt;
  logic                    hold_valid, load_now, tready;
  logic                    done_nxt, under_nxt, miso_q, miso_nxt;
  logic                    sclk_rise, sclk_fall, cs_rise, cs_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(SPI_CPOL)) u_sync_sclk (
    .clk(clk), .reset(reset), .din(bus.s_spi_clk), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(SPI_CS_IDLE)) u_sync_cs (
    .clk(clk), .reset(reset), .din(bus.s_spi_cs), .rise(cs_rise), .fall(cs_fall)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // CS edges take priority over a coincident SCLK fall in every state.
  always_comb begin
    state_nxt  = state;
    shreg_nxt  = shreg;
    bitcnt_nxt = bitcnt;
    load_now   = 1'b0;
    done_nxt   = 1'b0;
    under_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cs_fall) begin
          load_now   = 1'b1;
          state_nxt  = ST_SHIFT;
          shreg_nxt  = hold_valid ? hold_data : IDLE_PATTERN;
          under_nxt  = ~hold_valid;
          bitcnt_nxt = LAST_BIT;
        end
      end
      ST_SHIFT: begin
        if (cs_rise) begin
          state_nxt = ST_IDLE;
        end else if (sclk_fall) begin
          shreg_nxt = shreg << 1;
          if (bitcnt == '0) begin
            state_nxt = ST_DONE;
            done_nxt  = 1'b1;
          end else begin
            bitcnt_nxt = bitcnt - 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (cs_rise)        state_nxt = ST_IDLE;
        else if (sclk_fall) shreg_nxt = shreg << 1;
      end
      default: state_nxt = ST_IDLE;
    endcase
    miso_nxt = (state_nxt != ST_IDLE) & shreg_nxt[SAMPLE_WIDTH-1];
  end

  assign tready            = ~hold_valid | load_now;
  assign bus.s_axis_tready = tready;
  assign bus.s_spi_miso    = miso_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg        <= '0;
      bitcnt       <= '0;
      hold_valid   <= 1'b0;
      hold_data    <= '0;
      miso_q       <= 1'b0;
      frame_done   <= 1'b0;
      underrun     <= 1'b0;
      frame_cnt    <= '0;
      underrun_cnt <= '0;
    end else begin
      shreg      <= shreg_nxt;
      bitcnt     <= bitcnt_nxt;
      miso_q     <= miso_nxt;
      frame_done <= done_nxt;
      underrun   <= under_nxt;
      if (done_nxt)
        frame_cnt <= frame_cnt + 1'b1;
      if (under_nxt && underrun_cnt != {CNT_WIDTH{1'b1}})
        underrun_cnt <= underrun_cnt + 1'b1;
      // A new sample may enter in the same cycle the old one is loaded.
      if (bus.s_axis_tvalid && tready) begin
        hold_data  <= bus.s_axis_tdata[SAMPLE_WIDTH-1:0];
        hold_valid <= 1'b1;
      end else if (load_now) begin
        hold_valid <= 1'b0;
      end
    end
  end

endmodule
